sobel_window_sequencer: RTL and testbench

//  Frame-level controller that sequences the Sobel datapath for a raster pixel stream.
//  - Tracks row/column position and drives write/read control for three external line buffers.
//  - Flags each pixel that completes a full 3x3 window, for the downstream convolution stage.
//  - Throttles upstream with in_ready; honours downstream back-pressure (out_ready).

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_window_sequencer_if.sv | 33 +++
 rtl/sobel_raster_counter.sv | 54 +++++
 rtl/sobel_window_sequencer.sv | 126 ++++++++++++
 tb/tb_sobel_window_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer and filter datapath:
// frame geometry defaults, controller state encoding, line-buffer rotation.
package sobel_pkg;

  localparam int N_DEFAULT = 720;
  localparam int M_DEFAULT = 1280;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PRIME  = 2'b01,
    STREAM = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Three line buffers used as a ring: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] lb_next(input logic [1:0] sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// Control/handshake bundle between the window sequencer, its pixel source,
// the line buffers and the downstream convolution stage.
interface sobel_window_sequencer_if #(
  parameter int CW = $clog2(sobel_pkg::M_DEFAULT),
  parameter int RW = $clog2(sobel_pkg::N_DEFAULT)
);
  logic          start;
  logic          abort;
  logic          data_valid;
  logic          in_ready;
  logic          lb_wr_en;
  logic [1:0]    lb_wr_sel;
  logic [1:0]    lb_top_sel;
  logic [CW-1:0] lb_addr;
  logic          win_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  modport slave (
    input  start, abort, data_valid, out_ready,
    output in_ready, lb_wr_en, lb_wr_sel, lb_top_sel, lb_addr,
           win_valid, win_row, win_col, busy, frame_done
  );

  modport master (
    output start, abort, data_valid, out_ready,
    input  in_ready, lb_wr_en, lb_wr_sel, lb_top_sel, lb_addr,
           win_valid, win_row, win_col, busy, frame_done
  );
endinterface

// File: rtl/sobel_raster_counter.sv
// Raster row/column position counter advanced once per accepted pixel;
// wraps at the end of each row and back to (0,0) at the end of the frame.
module sobel_raster_counter #(
  parameter int N  = 720,
  parameter int M  = 1280,
  parameter int CW = $clog2(M),
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          row_end,
  output logic          frame_end
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign row_end   = (col_q == CW'(M - 1));
  assign frame_end = row_end && (row_q == RW'(N - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (row_end) begin
        col_d = '0;
        row_d = frame_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/sobel_window_sequencer.sv
// Frame controller for the Sobel datapath: primes two rows into the line buffers,
// then flags every pixel that completes a 3x3 window, honouring downstream back-pressure.
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int M  = M_DEFAULT,
  parameter int CW = $clog2(M),
  parameter int RW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sobel_window_sequencer_if.slave  bus
);

  state_t        state_q, state_d;
  logic [1:0]    lb_wr_sel_q, lb_wr_sel_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          frame_done_q, frame_done_d;

  logic          in_ready;
  logic          xfer;
  logic          cnt_clr;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          row_end;
  logic          frame_end;

  sobel_raster_counter #(.N(N), .M(M), .CW(CW), .RW(RW)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (xfer),
    .row       (row),
    .col       (col),
    .row_end   (row_end),
    .frame_end (frame_end)
  );

  always_comb begin
    state_d      = state_q;
    lb_wr_sel_d  = lb_wr_sel_q;
    win_valid_d  = win_valid_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;
    cnt_clr      = 1'b0;
    in_ready     = 1'b0;

    // A held window stalls the source, so a new window can only load when the old one leaves.
    unique case (state_q)
      PRIME:   in_ready = 1'b1;
      STREAM:  in_ready = ~(win_valid_q & ~bus.out_ready);
      default: in_ready = 1'b0;
    endcase
    xfer = bus.data_valid & in_ready;

    if (win_valid_q && bus.out_ready) begin
      win_valid_d = 1'b0;
      win_row_d   = '0;
      win_col_d   = '0;
    end
    if (xfer && (state_q == STREAM) && (col >= CW'(2))) begin
      win_valid_d = 1'b1;
      win_row_d   = row;
      win_col_d   = col;
    end
    if (xfer && row_end) lb_wr_sel_d = lb_next(lb_wr_sel_q);

    case (state_q)
      IDLE: if (bus.start) begin
        state_d     = PRIME;
        cnt_clr     = 1'b1;
        lb_wr_sel_d = 2'd0;
      end
      PRIME:  if (xfer && row_end && (row == RW'(1))) state_d = STREAM;
      STREAM: if (xfer && frame_end) state_d = DONE;
      DONE: if (!win_valid_q || bus.out_ready) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d      = IDLE;
      cnt_clr      = 1'b1;
      lb_wr_sel_d  = 2'd0;
      win_valid_d  = 1'b0;
      win_row_d    = '0;
      win_col_d    = '0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lb_wr_sel_q  <= 2'd0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lb_wr_sel_q  <= lb_wr_sel_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.lb_wr_en   = xfer;
  assign bus.lb_wr_sel  = lb_wr_sel_q;
  assign bus.lb_top_sel = lb_next(lb_wr_sel_q);
  assign bus.lb_addr    = col;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Bench for sobel_window_sequencer on a 4x5 frame: a pixel-index reference model
// predicts every output each cycle; windows consumed per frame are compared to the raster list.
module tb_sobel_window_sequencer;

  localparam int N  = 4;
  localparam int M  = 5;
  localparam int CW = $clog2(M);
  localparam int RW = $clog2(N);
  localparam int NWIN = (N - 2) * (M - 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sobel_window_sequencer_if #(.CW(CW), .RW(RW)) bus ();

  sobel_window_sequencer #(.N(N), .M(M), .CW(CW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: frame progress is the count of accepted pixels.
  bit m_active;
  int m_idx;
  bit m_pend;
  int m_pr, m_pc;
  bit m_fd;
  int fd_seen;
  int log_r[$];
  int log_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_pend   = 1'b0;
    m_fd     = 1'b0;
  endtask

  task automatic step(input logic dv, input logic ordy, input logic st, input logic ab);
    bit exp_ir, xfer, pend_old, in_done;
    @(negedge clk);
    bus.data_valid = dv;
    bus.out_ready  = ordy;
    bus.start      = st;
    bus.abort      = ab;
    #1;
    exp_ir = m_active && (m_idx < N * M) && !(m_pend && !ordy);
    xfer   = dv && exp_ir;
    chk("busy",       32'(bus.busy),       32'(m_active));
    chk("in_ready",   32'(bus.in_ready),   32'(exp_ir));
    chk("lb_wr_en",   32'(bus.lb_wr_en),   32'(xfer));
    chk("lb_addr",    32'(bus.lb_addr),    32'(m_idx % M));
    chk("lb_wr_sel",  32'(bus.lb_wr_sel),  32'((m_idx / M) % 3));
    chk("lb_top_sel", 32'(bus.lb_top_sel), 32'((m_idx / M + 1) % 3));
    chk("win_valid",  32'(bus.win_valid),  32'(m_pend));
    chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
    if (m_pend) begin
      chk("win_row", 32'(bus.win_row), 32'(m_pr));
      chk("win_col", 32'(bus.win_col), 32'(m_pc));
    end
    if (m_fd) fd_seen++;

    m_fd = 1'b0;
    if (ab) begin
      model_reset();
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
    end else begin
      pend_old = m_pend;
      in_done  = (m_idx == N * M);
      if (m_pend && ordy) begin
        log_r.push_back(m_pr);
        log_c.push_back(m_pc);
        m_pend = 1'b0;
      end
      if (xfer) begin
        if ((m_idx / M >= 2) && (m_idx % M >= 2)) begin
          m_pend = 1'b1;
          m_pr   = m_idx / M;
          m_pc   = m_idx % M;
        end
        m_idx++;
      end
      if (in_done && (!pend_old || ordy)) begin
        m_fd     = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  // dv_mode: 0 always valid, 1 alternating, 2 random. or_mode: 0 always ready, 1 stall (2,2) 3 cycles, 2 random.
  task automatic run_frame(input int dv_mode, input int or_mode, input string tag);
    logic dv, ordy;
    int hold;
    hold = 0;
    log_r.delete();
    log_c.delete();
    fd_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 400 && fd_seen == 0; k++) begin
      case (dv_mode)
        0:       dv = 1'b1;
        1:       dv = (k % 2 == 0);
        default: dv = 1'($urandom_range(0, 1));
      endcase
      case (or_mode)
        0: ordy = 1'b1;
        1: begin
          ordy = 1'b1;
          if (m_pend && m_pr == 2 && m_pc == 2 && hold < 3) begin
            ordy = 1'b0;
            hold++;
          end
        end
        default: ordy = ($urandom_range(0, 3) != 0);
      endcase
      step(dv, ordy, 1'b0, 1'b0);
    end
    chk({tag, "_frame_done_count"}, 32'(fd_seen), 32'd1);
    chk({tag, "_win_count"}, 32'(log_r.size()), 32'(NWIN));
    for (int i = 0; i < NWIN && i < log_r.size(); i++) begin
      chk({tag, "_win_r"}, 32'(log_r[i]), 32'(2 + i / (M - 2)));
      chk({tag, "_win_c"}, 32'(log_c[i]), 32'(2 + i % (M - 2)));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.data_valid = 1'b0;
    bus.out_ready  = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    fd_seen = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),   32'd0);
    chk("rst_win_valid",  32'(bus.win_valid),  32'd0);
    chk("rst_lb_wr_sel",  32'(bus.lb_wr_sel),  32'd0);
    chk("rst_lb_top_sel", 32'(bus.lb_top_sel), 32'd1);
    chk("rst_lb_addr",    32'(bus.lb_addr),    32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Full frame, no stalls
    run_frame(0, 0, "full");

    // Mid-STREAM asynchronous reset
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && m_idx < 13; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("midrst_win_valid", 32'(bus.win_valid), 32'd0);
    chk("midrst_lb_wr_sel", 32'(bus.lb_wr_sel), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fd_seen = 0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_no_frame_done", 32'(fd_seen), 32'd0);

    // Back-pressure on window (2,2)
    run_frame(0, 1, "bp");

    // Start ignored mid-STREAM, then abort at row 2
    fd_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && m_idx < 11; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_no_frame_done", 32'(fd_seen), 32'd0);
    run_frame(0, 0, "after_abort");

    // Gapped input
    run_frame(1, 0, "gapped");

    // Randomized input and back-pressure
    for (int f = 0; f < 4; f++) run_frame(2, 2, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
